// File: rtl/ex_exec_unit.sv
// ex_exec_unit: RV32 execute stage between ID/EX and EX/MEM.
// Integer ALU, branch/jump resolution and a registered valid/ready output slot.
// Define EX_MULDIV_EN to build the iterative multiply/divide datapath (ops 20-27);
// without it those ops complete in one cycle as illegal and o_busy stays 0.
module ex_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_use_imm,
  input  logic [XLEN-1:0] i_pc,
  input  logic [4:0]      i_rd,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target,
  output logic            o_illegal,
  output logic            o_busy
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]        op2;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0]        alu_res;
  logic [XLEN-1:0]        alu_tgt;
  logic                   alu_redir;
  logic                   alu_ill;

  logic                   slot_free;
  logic                   idle;
  logic                   accept;
  logic                   is_md;
  logic                   load_alu;
  logic                   md_done;
  logic [XLEN-1:0]        md_res;
  logic [4:0]             md_rd;

  assign op2       = i_use_imm ? i_imm : i_b;
  assign shamt     = op2[SHW-1:0];
  assign sra_res   = $signed(i_a) >>> shamt;
  assign slot_free = !o_valid || i_ready;
  assign o_ready   = idle && slot_free;
  assign accept    = i_valid && o_ready;
  assign load_alu  = accept && !is_md;

  // Single-cycle result, redirect and illegal decode for the op currently presented
  always_comb begin
    alu_res   = '0;
    alu_tgt   = '0;
    alu_redir = 1'b0;
    alu_ill   = 1'b0;
    case (i_op)
      5'd0:  alu_res = i_a + op2;
      5'd1:  alu_res = i_a - op2;
      5'd2:  alu_res = i_a << shamt;
      5'd3:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(op2))};
      5'd4:  alu_res = {{(XLEN-1){1'b0}}, (i_a < op2)};
      5'd5:  alu_res = i_a ^ op2;
      5'd6:  alu_res = i_a >> shamt;
      5'd7:  alu_res = sra_res;
      5'd8:  alu_res = i_a | op2;
      5'd9:  alu_res = i_a & op2;
      5'd10: alu_res = i_imm;
      5'd11: alu_res = i_pc + i_imm;
      5'd12: begin
        alu_res   = i_pc + XLEN'(4);
        alu_tgt   = i_pc + i_imm;
        alu_redir = 1'b1;
      end
      5'd13: begin
        alu_res   = i_pc + XLEN'(4);
        alu_tgt   = (i_a + i_imm) & ~XLEN'(1);
        alu_redir = 1'b1;
      end
      5'd14: begin alu_tgt = i_pc + i_imm; alu_redir = (i_a == i_b); end
      5'd15: begin alu_tgt = i_pc + i_imm; alu_redir = (i_a != i_b); end
      5'd16: begin alu_tgt = i_pc + i_imm; alu_redir = ($signed(i_a) < $signed(i_b)); end
      5'd17: begin alu_tgt = i_pc + i_imm; alu_redir = ($signed(i_a) >= $signed(i_b)); end
      5'd18: begin alu_tgt = i_pc + i_imm; alu_redir = (i_a < i_b); end
      5'd19: begin alu_tgt = i_pc + i_imm; alu_redir = (i_a >= i_b); end
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef EX_MULDIV_EN

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  state_t              state;
  state_t              state_nx;
  logic [SHW-1:0]      cnt;
  logic                last;
  logic [1:0]          md_op;
  logic [4:0]          md_rd_q;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   acc_step;
  logic [XLEN-1:0]     mcand;
  logic [XLEN-1:0]     a_raw;
  logic                neg_hi;
  logic                neg_rem;
  logic                div0;

  logic                sa_sig;
  logic                sb_sig;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;

  assign is_md   = (i_op >= 5'd20) && (i_op <= 5'd27);
  assign idle    = (state == ST_IDLE);
  assign o_busy  = !idle;
  assign last    = (cnt == SHW'(XLEN - 1));
  assign md_done = !idle && last && slot_free;
  assign md_rd   = md_rd_q;

  assign a_neg = sa_sig && i_a[XLEN-1];
  assign b_neg = sb_sig && i_b[XLEN-1];
  assign a_mag = a_neg ? -i_a : i_a;
  assign b_mag = b_neg ? -i_b : i_b;

  // Which operands of the incoming mul/div variant are treated as signed
  always_comb begin
    sa_sig = 1'b0;
    sb_sig = 1'b0;
    case (i_op)
      5'd20, 5'd21, 5'd24, 5'd26: begin sa_sig = 1'b1; sb_sig = 1'b1; end
      5'd22:                      sa_sig = 1'b1;
      default:                    ;
    endcase
  end

  // State register; reset aborts any iteration in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next state: start on an accepted mul/div, return once the result enters the slot
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && is_md) state_nx = (i_op < 5'd24) ? ST_MUL : ST_DIV;
      ST_MUL,
      ST_DIV:  if (md_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift[XLEN-1:0] - mcand;

  // One shift-add or restoring-divide step on the {hi,lo} / {rem,quo} accumulator
  always_comb begin
    acc_step = acc;
    if (state == ST_MUL) begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end else if (state == ST_DIV) begin
      if (div_shift >= {1'b0, mcand}) acc_step = {div_diff, acc[XLEN-2:0], 1'b1};
      else                            acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  // Operand capture at acceptance, then one step per cycle; the last step is held until the slot frees
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt     <= '0;
      md_op   <= '0;
      md_rd_q <= '0;
      acc     <= '0;
      mcand   <= '0;
      a_raw   <= '0;
      neg_hi  <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (accept && is_md) begin
      cnt     <= '0;
      md_op   <= i_op[1:0];
      md_rd_q <= i_rd;
      a_raw   <= i_a;
      div0    <= (i_b == '0);
      neg_hi  <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (i_op < 5'd24) begin
        acc   <= {{XLEN{1'b0}}, b_mag};
        mcand <= a_mag;
      end else begin
        acc   <= {{XLEN{1'b0}}, a_mag};
        mcand <= b_mag;
      end
    end else if (!idle && !last) begin
      acc <= acc_step;
      cnt <= cnt + SHW'(1);
    end
  end

  // Sign correction and variant selection on the final step's value
  always_comb begin
    prod = neg_hi ? -acc_step : acc_step;
    quo  = acc_step[XLEN-1:0];
    rem  = acc_step[2*XLEN-1:XLEN];
    if (div0) begin
      quo = '1;
      rem = a_raw;
    end else begin
      if (neg_hi)  quo = -quo;
      if (neg_rem) rem = -rem;
    end
    md_res = '0;
    if (state == ST_MUL)      md_res = (md_op == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (state == ST_DIV) md_res = md_op[1] ? rem : quo;
  end

`else

  assign is_md   = 1'b0;
  assign idle    = 1'b1;
  assign o_busy  = 1'b0;
  assign md_done = 1'b0;
  assign md_res  = '0;
  assign md_rd   = '0;

`endif

  // Output slot: load a single-cycle or finished mul/div result, otherwise drain when consumed
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_rd       <= '0;
      o_redirect <= 1'b0;
      o_target   <= '0;
      o_illegal  <= 1'b0;
    end else if (load_alu) begin
      o_valid    <= 1'b1;
      o_result   <= alu_res;
      o_rd       <= i_rd;
      o_redirect <= alu_redir;
      o_target   <= alu_tgt;
      o_illegal  <= alu_ill;
    end else if (md_done) begin
      o_valid    <= 1'b1;
      o_result   <= md_res;
      o_rd       <= md_rd;
      o_redirect <= 1'b0;
      o_target   <= '0;
      o_illegal  <= 1'b0;
    end else if (o_valid && i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_exec_unit.sv
// tb_ex_exec_unit: scoreboard bench for ex_exec_unit with a behavioural model
// of the RV32 execute semantics; mul/div expectations follow EX_MULDIV_EN.
`timescale 1ns/1ps
module tb_ex_exec_unit;

  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [4:0]      i_op = '0;
  logic [XLEN-1:0] i_a = '0;
  logic [XLEN-1:0] i_b = '0;
  logic [XLEN-1:0] i_imm = '0;
  logic            i_use_imm = 1'b0;
  logic [XLEN-1:0] i_pc = '0;
  logic [4:0]      i_rd = '0;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;
  logic            o_redirect;
  logic [XLEN-1:0] o_target;
  logic            o_illegal;
  logic            o_busy;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        redirect;
    logic [31:0] target;
    logic        chk_tgt;
    logic        illegal;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;
  int   waited;

  ex_exec_unit #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_imm(i_imm), .i_use_imm(i_use_imm),
    .i_pc(i_pc), .i_rd(i_rd), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd(o_rd), .o_redirect(o_redirect), .o_target(o_target),
    .o_illegal(o_illegal), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference behaviour of one operation, written from the ISA rules
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic use_imm, input logic [31:0] pc,
                                 input logic [4:0] rd);
    exp_t        e;
    logic [31:0] o2;
    int unsigned sh;
    longint      sa, sb;
    longint      ub;
    logic [63:0] p;
    int          ia, ib;
    logic        ovf;
    e.result = 32'd0; e.rd = rd; e.redirect = 1'b0; e.target = 32'd0; e.chk_tgt = 1'b0; e.illegal = 1'b0;
    o2 = use_imm ? imm : b;
    sh = int'(o2 % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  e.result = a + o2;
      5'd1:  e.result = a - o2;
      5'd2:  e.result = a << sh;
      5'd3:  e.result = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
      5'd4:  e.result = (a < o2) ? 32'd1 : 32'd0;
      5'd5:  e.result = a ^ o2;
      5'd6:  e.result = a >> sh;
      5'd7:  e.result = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      5'd8:  e.result = a | o2;
      5'd9:  e.result = a & o2;
      5'd10: e.result = imm;
      5'd11: e.result = pc + imm;
      5'd12: begin e.result = pc + 32'd4; e.target = pc + imm; e.redirect = 1'b1; e.chk_tgt = 1'b1; end
      5'd13: begin e.result = pc + 32'd4; e.target = (a + imm) & 32'hFFFF_FFFE; e.redirect = 1'b1; e.chk_tgt = 1'b1; end
      5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
        e.target  = pc + imm;
        e.chk_tgt = 1'b1;
        case (op)
          5'd14:   e.redirect = (a == b);
          5'd15:   e.redirect = (a != b);
          5'd16:   e.redirect = (ia < ib);
          5'd17:   e.redirect = (ia >= ib);
          5'd18:   e.redirect = (a < b);
          default: e.redirect = (a >= b);
        endcase
      end
`ifdef EX_MULDIV_EN
      5'd20: begin p = 64'(sa * sb); e.result = p[31:0]; end
      5'd21: begin p = 64'(sa * sb); e.result = p[63:32]; end
      5'd22: begin p = 64'(sa * ub); e.result = p[63:32]; end
      5'd23: begin p = {32'd0, a} * {32'd0, b}; e.result = p[63:32]; end
      5'd24: e.result = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      5'd25: e.result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd26: e.result = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      5'd27: e.result = (b == 0) ? a : a % b;
`endif
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      4:       return 32'(-$urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic checkSignal(input string name, input longint got, input longint req);
    tests++;
    if (got != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic ok;
    ok = (o_result == e.result) && (o_rd == e.rd) && (o_redirect == e.redirect) &&
         (o_illegal == e.illegal) && (!e.chk_tgt || (o_target == e.target));
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL scoreboard: got res=%h rd=%0d redir=%0b tgt=%h ill=%0b, required res=%h rd=%0d redir=%0b tgt=%h ill=%0b",
               o_result, o_rd, o_redirect, o_target, o_illegal,
               e.result, e.rd, e.redirect, e.target, e.illegal);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance with the number of stalled cycles
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic use_imm, input logic [31:0] pc,
                               output int stalls);
    logic [4:0] rd;
    rd = 5'($urandom_range(0, 31));
    i_op = op; i_a = a; i_b = b; i_imm = imm; i_use_imm = use_imm; i_pc = pc; i_rd = rd;
    i_valid = 1'b1;
    stalls = 0;
    @(negedge i_clk);
    while (!o_ready && stalls < 300) begin
      stalls++;
      @(negedge i_clk);
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, stalls);
    end else begin
      sb_q.push_back(model(op, a, b, imm, use_imm, pc, rd));
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_a = $urandom;
    i_b = $urandom;
  endtask

  task automatic drain();
    int n;
    ready_mode = 0;
    n = 0;
    while ((sb_q.size() != 0 || o_valid || o_busy) && n < 400) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkSignal("drain_done", longint'(sb_q.size()), 0);
  endtask

  // Downstream ready generator, updated away from the inputs and the sampling edge
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      case (ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(0, 3) != 0);
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every consumed result is popped from the scoreboard and compared
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_reset && o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_output: got res=%h rd=%0d, required no output", o_result, o_rd);
        end else begin
          e = sb_q.pop_front();
          checkOutput(e);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int m;
    logic [4:0] op;
    // Reset and reset values
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checkSignal("rst_valid", longint'(o_valid), 0);
    checkSignal("rst_result", longint'(o_result), 0);
    checkSignal("rst_rd", longint'(o_rd), 0);
    checkSignal("rst_redirect", longint'(o_redirect), 0);
    checkSignal("rst_target", longint'(o_target), 0);
    checkSignal("rst_illegal", longint'(o_illegal), 0);
    checkSignal("rst_busy", longint'(o_busy), 0);
    checkSignal("rst_ready", longint'(o_ready), 1);

    // Back-to-back single-cycle ops
    applyStimulus(5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 32'd0, waited);
    checkSignal("b2b_first_stall", waited, 0);
    applyStimulus(5'd1, 32'd3, 32'd5, 32'd0, 1'b0, 32'd0, waited);
    checkSignal("b2b_second_stall", waited, 0);
    applyStimulus(5'd7, 32'h8000_0010, 32'd4, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd3, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd16, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 1'b0, 32'h100, waited);
    applyStimulus(5'd13, 32'h203, 32'd0, 32'd0, 1'b0, 32'h40, waited);
    applyStimulus(5'd0, 32'd10, 32'd99, 32'hFFFF_FFFE, 1'b1, 32'd0, waited);
    applyStimulus(5'd30, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0, waited);
    drain();

    // Backpressure: slot holds while downstream stalls, then releases with no bubble
    ready_mode = 2;
    applyStimulus(5'd0, 32'd100, 32'd23, 32'd0, 1'b0, 32'd0, waited);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      checkSignal("bp_valid", longint'(o_valid), 1);
      checkSignal("bp_result", longint'(o_result), 123);
      checkSignal("bp_ready", longint'(o_ready), 0);
    end
    @(posedge i_clk);
    #1;
    ready_mode = 0;
    applyStimulus(5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'd0, waited);
    checkSignal("bp_release_stall", waited, 0);
    drain();

`ifdef EX_MULDIV_EN
    // Multi-cycle latency and busy window
    applyStimulus(5'd21, 32'h8000_0000, 32'd2, 32'd0, 1'b0, 32'd0, waited);
    checkSignal("md_busy_start", longint'(o_busy), 1);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkSignal("mulh_latency", n, XLEN);
    drain();
    applyStimulus(5'd24, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd26, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd25, 32'd1234, 32'd0, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd24, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd26, 32'hFFFF_FFF9, 32'd0, 32'd0, 1'b0, 32'd0, waited);
    applyStimulus(5'd22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, waited);
    drain();
`endif

    // Reset in the middle of a divide: nothing stale may appear afterwards
    ready_mode = 2;
    applyStimulus(5'd24, 32'd1000, 32'd7, 32'd0, 1'b0, 32'd0, waited);
    repeat (9) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    sb_q.delete();
    checkSignal("midrst_busy", longint'(o_busy), 0);
    checkSignal("midrst_valid", longint'(o_valid), 0);
    checkSignal("midrst_ready", longint'(o_ready), 1);
    ready_mode = 0;
    repeat (45) @(posedge i_clk);
    #1;

    // Randomised traffic with random downstream backpressure
    ready_mode = 1;
    for (int t = 0; t < 400; t++) begin
      m = $urandom_range(0, 9);
      op = (m < 7) ? 5'($urandom_range(0, 19)) : 5'($urandom_range(20, 31));
      applyStimulus(op, rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
                    {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, waited);
    end
    drain();
    checkSignal("scoreboard_empty", longint'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
